// File: rtl/assoc_cache.sv
// N-way set-associative read-only cache with true-LRU replacement, line refill
// over a level req / pulse ack memory port, flush, and hit/access statistics.
module assoc_cache #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int WORDS  = 4,
  parameter int SETS   = 256,
  parameter int WAYS   = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    cpu_req,
  input  logic [ADDR_W-1:0]       cpu_addr,
  output logic                    cpu_ready,
  output logic                    cpu_valid,
  output logic [DATA_W-1:0]       cpu_data,
  output logic                    cpu_hit,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_ack,
  input  logic [WORDS*DATA_W-1:0] mem_data,
  output logic [CNT_W-1:0]        hit_count,
  output logic [CNT_W-1:0]        access_count,
  output logic [1:0]              dbg_state
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESPOND} state_t;

  // Handshakes: cpu_req is taken on a rising edge where cpu_ready=1; cpu_valid
  // pulses one cycle per accepted request. mem_req is held (with mem_addr stable)
  // until a rising edge that samples mem_ack=1; mem_ack elsewhere is ignored.
  state_t state, state_nxt;

  logic [ADDR_W-1:0]       req_addr;
  logic [TAG_W-1:0]        req_tag;
  logic [IDX_W-1:0]        req_idx;
  logic [OFF_W-1:0]        req_off;

  logic                    valid_q  [SETS][WAYS];
  logic [WAY_W-1:0]        age_q    [SETS][WAYS];
  logic [TAG_W-1:0]        tag_mem  [WAYS][SETS];
  logic [WORDS*DATA_W-1:0] data_mem [WAYS][SETS];

  logic                    hit;
  logic                    inv_found;
  logic [WAY_W-1:0]        hit_way;
  logic [WAY_W-1:0]        victim;
  logic [WAY_W-1:0]        victim_q;
  logic [WAY_W-1:0]        upd_way;
  logic [WAY_W-1:0]        upd_age;
  logic                    upd_en;
  logic [DATA_W-1:0]       hit_word;
  logic [DATA_W-1:0]       fill_word;

  assign req_tag = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx = req_addr[OFF_W +: IDX_W];
  assign req_off = req_addr[OFF_W-1:0];

  assign cpu_ready = (state == IDLE);
  assign mem_req   = (state == REFILL);
  assign mem_addr  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign dbg_state = state;

  function automatic logic [DATA_W-1:0] word_sel(input logic [WORDS*DATA_W-1:0] line,
                                                 input logic [OFF_W-1:0] off);
    word_sel = '0;
    for (int i = 0; i < WORDS; i++)
      if (off == OFF_W'(i)) word_sel = line[i*DATA_W +: DATA_W];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!flush && cpu_req) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = hit ? IDLE : REFILL;
      REFILL:  if (mem_ack) state_nxt = RESPOND;
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Tag match, then victim choice: first invalid way, else the oldest way.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    victim    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[req_idx][w] && tag_mem[w][req_idx] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[req_idx][w]) begin
        inv_found = 1'b1;
        victim    = WAY_W'(w);
      end
    end
    if (!inv_found)
      for (int w = 0; w < WAYS; w++)
        if (age_q[req_idx][w] == WAY_W'(WAYS-1)) victim = WAY_W'(w);
  end

  assign hit_word  = word_sel(data_mem[hit_way][req_idx], req_off);
  assign fill_word = word_sel(mem_data, req_off);
  assign upd_en    = ((state == LOOKUP) && hit) || ((state == REFILL) && mem_ack);
  assign upd_way   = (state == LOOKUP) ? hit_way : victim_q;
  assign upd_age   = age_q[req_idx][upd_way];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          age_q[s][w]   <= WAY_W'(w);
        end
      req_addr     <= '0;
      victim_q     <= '0;
      cpu_valid    <= 1'b0;
      cpu_hit      <= 1'b0;
      cpu_data     <= '0;
      hit_count    <= '0;
      access_count <= '0;
    end else begin
      cpu_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            for (int s = 0; s < SETS; s++)
              for (int w = 0; w < WAYS; w++) begin
                valid_q[s][w] <= 1'b0;
                age_q[s][w]   <= WAY_W'(w);
              end
            hit_count    <= '0;
            access_count <= '0;
          end else if (cpu_req) begin
            req_addr <= cpu_addr;
          end
        end
        LOOKUP: begin
          if (hit) begin
            cpu_valid    <= 1'b1;
            cpu_hit      <= 1'b1;
            cpu_data     <= hit_word;
            hit_count    <= hit_count + 1'b1;
            access_count <= access_count + 1'b1;
          end else begin
            victim_q <= victim;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            valid_q[req_idx][victim_q] <= 1'b1;
            cpu_valid <= 1'b1;
            cpu_hit   <= 1'b0;
            cpu_data  <= fill_word;
          end
        end
        RESPOND: access_count <= access_count + 1'b1;
        default: ;
      endcase
      // LRU: touched way becomes youngest, ways younger than it age by one.
      if (upd_en)
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == upd_way)
            age_q[req_idx][w] <= '0;
          else if (age_q[req_idx][w] < upd_age)
            age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
        end
    end
  end

  // Tag and data arrays carry no reset; a line only becomes usable via valid_q.
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_ack) begin
      tag_mem[victim_q][req_idx]  <= req_tag;
      data_mem[victim_q][req_idx] <= mem_data;
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
// Bench for assoc_cache: directed read sequences against a word-equals-address
// memory model, with a scoreboard of expected {hit, data} responses.
module tb_assoc_cache;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int WORDS  = 4;
  localparam int CNT_W  = 16;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    flush = 1'b0;
  logic                    cpu_req = 1'b0;
  logic [ADDR_W-1:0]       cpu_addr = '0;
  logic                    cpu_ready, cpu_valid, cpu_hit, mem_req;
  logic [DATA_W-1:0]       cpu_data;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_ack = 1'b0;
  logic [WORDS*DATA_W-1:0] mem_data = '0;
  logic [CNT_W-1:0]        hit_count, access_count;
  logic [1:0]              dbg_state;

  logic                    d4_ready, d4_valid, d4_hit, d4_mem_req;
  logic [DATA_W-1:0]       d4_data;
  logic [ADDR_W-1:0]       d4_mem_addr;
  logic [3:0]              d4_hit_count, d4_access_count;
  logic [1:0]              d4_state;

  int checks = 0;
  int passes = 0;
  int ack_dly = 3;
  int req_cycles = 0;
  logic [ADDR_W-1:0] first_addr = '0;
  logic [DATA_W:0] exp_q[$];

  assoc_cache dut (
    .clk(clk), .rst(rst), .flush(flush), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_valid(cpu_valid), .cpu_data(cpu_data), .cpu_hit(cpu_hit),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .hit_count(hit_count), .access_count(access_count), .dbg_state(dbg_state)
  );

  // Same stimulus, narrow counters: only its statistics outputs are examined.
  assoc_cache #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(d4_ready), .cpu_valid(d4_valid), .cpu_data(d4_data), .cpu_hit(d4_hit),
    .mem_req(d4_mem_req), .mem_addr(d4_mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .hit_count(d4_hit_count), .access_count(d4_access_count), .dbg_state(d4_state)
  );

  always #5 clk = ~clk;

  // Memory: word i of a line equals line address + i, acked ack_dly cycles after mem_req rises.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req) begin
      if (req_cycles == 0) first_addr = mem_addr;
      if (req_cycles == ack_dly) begin
        mem_ack = 1'b1;
        for (int i = 0; i < WORDS; i++)
          mem_data[i*DATA_W +: DATA_W] = 32'(mem_addr) + 32'(i);
        checks++;
        if (mem_addr !== first_addr || mem_addr[1:0] !== 2'b00)
          $display("FAIL mem_addr: got %0d, first %0d, must be stable and 4-aligned", mem_addr, first_addr);
        else passes++;
      end
      req_cycles++;
    end else begin
      req_cycles = 0;
    end
  end

  // Scoreboard: every cpu_valid pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (rst && cpu_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_valid: got data %0d hit %0b, expected no response", cpu_data, cpu_hit);
      end else begin
        logic [DATA_W:0] e;
        e = exp_q.pop_front();
        if ({cpu_hit, cpu_data} !== e)
          $display("FAIL response: got hit %0b data %0d, expected hit %0b data %0d",
                   cpu_hit, cpu_data, e[DATA_W], e[DATA_W-1:0]);
        else passes++;
      end
    end
  end

  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic exp_hit, input int exp_lat);
    int n;
    exp_q.push_back({exp_hit, 32'(addr)});
    cpu_req  = 1'b1;
    cpu_addr = addr;
    @(negedge clk);
    cpu_req = 1'b0;
    n = 1;
    while (!cpu_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== exp_lat)
      $display("FAIL latency addr %0d: got %0d cycles, expected %0d", addr, n, exp_lat);
    else passes++;
    checks++;
    if (cpu_ready !== exp_hit)
      $display("FAIL ready_at_valid addr %0d: got %0b, expected %0b", addr, cpu_ready, exp_hit);
    else passes++;
    n = 0;
    while (!cpu_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic check_counts(input string tag, input int eh, input int ea);
    checks++;
    if (hit_count !== CNT_W'(eh) || access_count !== CNT_W'(ea))
      $display("FAIL %s counters: got hit %0d access %0d, expected hit %0d access %0d",
               tag, hit_count, access_count, eh, ea);
    else passes++;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({cpu_ready, cpu_valid, cpu_hit, mem_req} !== 4'b1000 || cpu_data !== '0 || mem_addr !== '0)
      $display("FAIL reset_outputs: got ready %0b valid %0b hit %0b mem_req %0b data %0d mem_addr %0d, expected 1 0 0 0 0 0",
               cpu_ready, cpu_valid, cpu_hit, mem_req, cpu_data, mem_addr);
    else passes++;
    check_counts("reset", 0, 0);
    checks++;
    if (dbg_state !== 2'd0 || d4_hit_count !== 4'd0)
      $display("FAIL reset_state: got state %0d d4_hits %0d, expected 0 0", dbg_state, d4_hit_count);
    else passes++;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_miss_hit();
    do_read(15'd1024, 1'b0, 6);
    do_read(15'd1027, 1'b1, 2);
    check_counts("miss_hit", 1, 2);
  endtask

  task automatic test_eviction();
    do_flush();
    do_read(15'd1024, 1'b0, 6);
    do_read(15'd0,    1'b0, 6);
    do_read(15'd2048, 1'b0, 6);
    do_read(15'd0,    1'b1, 2);
    do_read(15'd1024, 1'b0, 6);
    do_read(15'd0,    1'b1, 2);
    do_read(15'd2048, 1'b0, 6);
    check_counts("eviction", 2, 7);
  endtask

  task automatic test_flush_drop();
    do_flush();
    do_read(15'd1024, 1'b0, 6);
    flush    = 1'b1;
    cpu_req  = 1'b1;
    cpu_addr = 15'd1024;
    @(negedge clk);
    flush   = 1'b0;
    cpu_req = 1'b0;
    repeat (4) @(negedge clk);
    check_counts("flush_drop", 0, 0);
    checks++;
    if (dbg_state !== 2'd0 || cpu_ready !== 1'b1)
      $display("FAIL flush_idle: got state %0d ready %0b, expected 0 1", dbg_state, cpu_ready);
    else passes++;
    do_read(15'd1024, 1'b0, 6);
  endtask

  task automatic test_reset_refill();
    int n;
    do_flush();
    cpu_req  = 1'b1;
    cpu_addr = 15'd4;
    @(negedge clk);
    cpu_req = 1'b0;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!mem_req) $display("FAIL refill_timeout: mem_req got %0b, expected 1", mem_req);
    else passes++;
    rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || dbg_state !== 2'd0 || cpu_ready !== 1'b1)
      $display("FAIL reset_mid_refill: got mem_req %0b state %0d ready %0b, expected 0 0 1",
               mem_req, dbg_state, cpu_ready);
    else passes++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    do_read(15'd4, 1'b0, 6);
    check_counts("after_reset", 0, 1);
  endtask

  task automatic test_back_to_back();
    do_flush();
    ack_dly = 0;
    do_read(15'd1024, 1'b0, 3);
    do_read(15'd1025, 1'b1, 2);
    do_read(15'd1026, 1'b1, 2);
    do_read(15'd5000, 1'b0, 3);
    ack_dly = 3;
    check_counts("back_to_back", 2, 4);
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] a;
    do_flush();
    do_read(15'd4096, 1'b0, 6);
    for (int i = 0; i < 17; i++) begin
      a = 15'd4096 + 15'(i % 4);
      do_read(a, 1'b1, 2);
    end
    check_counts("wrap_wide", 17, 18);
    checks++;
    if (d4_hit_count !== 4'd1 || d4_access_count !== 4'd2)
      $display("FAIL wrap_narrow: got hit %0d access %0d, expected 1 2", d4_hit_count, d4_access_count);
    else passes++;
  endtask

  task automatic test_sweep();
    logic [ADDR_W-1:0] a;
    do_flush();
    for (int i = 1024; i <= 9215; i++) begin
      a = 15'(i);
      do_read(a, a[1:0] != 2'b00, (a[1:0] == 2'b00) ? 6 : 2);
    end
    check_counts("sweep", 6144, 8192);
    checks++;
    if (d4_hit_count !== 4'd0 || d4_access_count !== 4'd0)
      $display("FAIL sweep_narrow: got hit %0d access %0d, expected 0 0", d4_hit_count, d4_access_count);
    else passes++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_miss_hit();
    test_eviction();
    test_flush_drop();
    test_reset_refill();
    test_back_to_back();
    test_wrap();
    test_sweep();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL missing_responses: got %0d outstanding, expected 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
